// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the seven-segment scan multiplexer.
package seg_scan_pkg;

    localparam int NDIG  = 8;
    localparam int IDX_W = 3;

    typedef logic [7:0] seg_pat_t;

    localparam seg_pat_t        SEG_OFF = 8'hFF;
    localparam logic [NDIG-1:0] AN_OFF  = 8'hFF;

endpackage

// File: rtl/seg_scan_timebase.sv
// Slot timebase: cnt runs 0..DIV-1 per digit slot, idx walks the eight slots.
module seg_scan_timebase
    import seg_scan_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int DIV   = 50000
) (
    input  logic             clk,
    input  logic             rst,
    output logic [DIV_W-1:0] cnt,
    output logic [IDX_W-1:0] idx,
    output logic             frame_start
);

    logic [DIV_W-1:0] cnt_d, cnt_q;
    logic [IDX_W-1:0] idx_d, idx_q;

    // NOTE: every _d gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == DIV_W'(DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 1'b1;
        end
    end

    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign cnt         = cnt_q;
    assign idx         = idx_q;
    assign frame_start = (cnt_q == '0) && (idx_q == '0);

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scanner with per-frame shadow latching and slot blanking.
// Optional brightness PWM is compiled in with SEG_SCAN_PWM_EN.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int DIV   = 50000,
    parameter int BLANK = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [8*NDIG-1:0]   seg_in,
    input  logic [NDIG-1:0]     digit_en,
`ifdef SEG_SCAN_PWM_EN
    input  logic [3:0]          bright,
`endif
    output logic [7:0]          seg_out,
    output logic [NDIG-1:0]     an_out,
    output logic                frame_tick
);

    logic [DIV_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             frame_start;

    seg_scan_timebase #(
        .DIV_W (DIV_W),
        .DIV   (DIV)
    ) u_timebase (
        .clk         (clk),
        .rst         (rst),
        .cnt         (cnt),
        .idx         (idx),
        .frame_start (frame_start)
    );

    seg_pat_t        shadow_seg_d [NDIG];
    seg_pat_t        shadow_seg_q [NDIG];
    logic [NDIG-1:0] shadow_en_d, shadow_en_q;
`ifdef SEG_SCAN_PWM_EN
    logic [3:0]      shadow_bright_d, shadow_bright_q;
`endif
    seg_pat_t        seg_d, seg_q;
    logic [NDIG-1:0] an_d, an_q;
    logic            frame_tick_d, frame_tick_q;
    logic            pwm_gate;
    logic            drive;
    logic [NDIG-1:0] an_onehot;

    always_comb begin
        shadow_seg_d = shadow_seg_q;
        shadow_en_d  = shadow_en_q;
`ifdef SEG_SCAN_PWM_EN
        shadow_bright_d = shadow_bright_q;
`endif
        if (frame_start) begin
            for (int i = 0; i < NDIG; i++) begin
                shadow_seg_d[i] = seg_in[8*i +: 8];
            end
            shadow_en_d = digit_en;
`ifdef SEG_SCAN_PWM_EN
            shadow_bright_d = bright;
`endif
        end

`ifdef SEG_SCAN_PWM_EN
        pwm_gate = (shadow_bright_q == 4'hF) || (cnt[3:0] < shadow_bright_q);
`else
        pwm_gate = 1'b1;
`endif
        // Drive decisions use the shadows, never the live inputs, so a frame never tears.
        drive     = (cnt >= DIV_W'(BLANK)) && shadow_en_q[idx] && pwm_gate;
        an_onehot = NDIG'(1) << idx;

        seg_d        = drive ? shadow_seg_q[idx] : SEG_OFF;
        an_d         = drive ? ~an_onehot : AN_OFF;
        frame_tick_d = frame_start;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the shadow array is reset so an enabled digit can never flash stale or unknown data.
            for (int i = 0; i < NDIG; i++) begin
                shadow_seg_q[i] <= SEG_OFF;
            end
            shadow_en_q  <= '0;
`ifdef SEG_SCAN_PWM_EN
            shadow_bright_q <= 4'hF;
`endif
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            shadow_seg_q <= shadow_seg_d;
            shadow_en_q  <= shadow_en_d;
`ifdef SEG_SCAN_PWM_EN
            shadow_bright_q <= shadow_bright_d;
`endif
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg_out    = seg_q;
    assign an_out     = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: reset/scan vector table plus scoreboarded multi-frame sequences.
module tb_seg_scan_mux;
    import seg_scan_pkg::*;

    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int FRAME = 8 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] seg_in;
    logic [7:0]  digit_en;
    logic [7:0]  seg_out;
    logic [7:0]  an_out;
    logic        frame_tick;

    always #5 clk = ~clk;

`ifdef SEG_SCAN_PWM_EN
    logic [3:0] bright = 4'hF;
`endif

    seg_scan_mux #(.DIV_W(16), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .digit_en   (digit_en),
`ifdef SEG_SCAN_PWM_EN
        .bright     (bright),
`endif
        .seg_out    (seg_out),
        .an_out     (an_out),
        .frame_tick (frame_tick)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] an;
        logic [7:0] seg;
        logic       tick;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [7:0] an;
        logic [7:0] seg;
        logic       tick;
    } vec_t;

    exp_t sb_q[$];

    // Reference model indexed by cycles since reset release rather than by counters.
    logic [7:0] m_seg [8];
    logic [7:0] m_en;
    int         m_k;

    task automatic model_step(output exp_t e);
        int         p;
        int         slot;
        int         c;
        logic [7:0] one;
        one = 8'h01;
        if (!rst) begin
            e   = '{an: 8'hFF, seg: 8'hFF, tick: 1'b0};
            m_k = 0;
            for (int i = 0; i < 8; i++) m_seg[i] = 8'hFF;
            m_en = 8'h00;
        end else begin
            p    = m_k % FRAME;
            slot = p / DIV;
            c    = p % DIV;
            if (p == 0) begin
                for (int i = 0; i < 8; i++) m_seg[i] = seg_in[8*i +: 8];
                m_en = digit_en;
            end
            e.tick = (p == 0);
            if (c >= BLANK && m_en[slot]) begin
                e.an  = ~(one << slot);
                e.seg = m_seg[slot];
            end else begin
                e.an  = 8'hFF;
                e.seg = 8'hFF;
            end
            m_k++;
        end
    endtask

    task automatic cycle(input string tag);
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_an"},   an_out,     e.an);
            check({tag, "_seg"},  seg_out,    e.seg);
            check({tag, "_tick"}, frame_tick, e.tick);
        end
    endtask

    task automatic run(input int n, input string tag);
        exp_t e;
        repeat (n) begin
            model_step(e);
            sb_q.push_back(e);
            cycle(tag);
        end
    endtask

`ifdef SEG_SCAN_PWM_EN
    logic        rst_p;
    logic [3:0]  bright_p;
    logic [7:0]  seg_out_p;
    logic [7:0]  an_out_p;
    logic        frame_tick_p;

    seg_scan_mux #(.DIV_W(16), .DIV(32), .BLANK(1)) dut_pwm (
        .clk        (clk),
        .rst        (rst_p),
        .seg_in     (64'hFFFF_FFFF_FFFF_FF3C),
        .digit_en   (8'h01),
        .bright     (bright_p),
        .seg_out    (seg_out_p),
        .an_out     (an_out_p),
        .frame_tick (frame_tick_p)
    );

    task automatic pwm_run(input logic [3:0] b);
        int  lit;
        logic exp_low;
        rst_p    = 1'b0;
        bright_p = b;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_p = 1'b1;
        lit   = 0;
        for (int k = 0; k < 32; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_low = (k >= 1) && ((b == 4'hF) || ((k % 16) < int'(b)));
            check("pwm_an", an_out_p, exp_low ? 8'hFE : 8'hFF);
            if (an_out_p != 8'hFF) lit++;
        end
        check("pwm_lit_count", lit, (b == 4'hF) ? 31 : (b == 4'd4) ? 7 : (b == 4'd0) ? 0 : lit);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [16];
        exp_t e;
        int   lit;

        vecs[0]  = '{1'b0, 8'hFF, 8'hFF, 1'b0};
        vecs[1]  = '{1'b0, 8'hFF, 8'hFF, 1'b0};
        vecs[2]  = '{1'b1, 8'hFF, 8'hFF, 1'b1};
        vecs[3]  = '{1'b1, 8'hFE, 8'h10, 1'b0};
        vecs[4]  = '{1'b1, 8'hFE, 8'h10, 1'b0};
        vecs[5]  = '{1'b1, 8'hFE, 8'h10, 1'b0};
        vecs[6]  = '{1'b1, 8'hFF, 8'hFF, 1'b0};
        vecs[7]  = '{1'b1, 8'hFD, 8'h11, 1'b0};
        vecs[8]  = '{1'b1, 8'hFD, 8'h11, 1'b0};
        vecs[9]  = '{1'b1, 8'hFD, 8'h11, 1'b0};
        vecs[10] = '{1'b1, 8'hFF, 8'hFF, 1'b0};
        vecs[11] = '{1'b1, 8'hFB, 8'h12, 1'b0};
        vecs[12] = '{1'b1, 8'hFB, 8'h12, 1'b0};
        vecs[13] = '{1'b1, 8'hFB, 8'h12, 1'b0};
        vecs[14] = '{1'b1, 8'hFF, 8'hFF, 1'b0};
        vecs[15] = '{1'b1, 8'hF7, 8'h13, 1'b0};

`ifdef SEG_SCAN_PWM_EN
        rst_p    = 1'b0;
        bright_p = 4'hF;
`endif
        rst      = 1'b0;
        digit_en = 8'hFF;
        for (int i = 0; i < 8; i++) seg_in[8*i +: 8] = 8'h10 + 8'(i);

        // Reset and first slots of the first frame from the fixed table; model advances in step.
        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            model_step(e);
            sb_q.push_back('{an: vecs[i].an, seg: vecs[i].seg, tick: vecs[i].tick});
            cycle("vec");
        end

        // Mid-frame edits during slot 3 stay invisible until the next frame.
        seg_in[7:0] = 8'hC0;
        digit_en    = 8'b1111_1011;
        run(FRAME - m_k, "frame1");

        lit = 0;
        repeat (FRAME) begin
            model_step(e);
            sb_q.push_back(e);
            cycle("frame2");
            if (an_out != 8'hFF) lit++;
        end
        check("frame2_lit_cycles", lit, 7 * (DIV - BLANK));

        // Reset in the middle of slot 5, held for two cycles.
        run(5 * DIV + 1, "pre_reset");
        rst = 1'b0;
        run(2, "in_reset");
        rst = 1'b1;
        run(2 * FRAME, "restart");

`ifdef SEG_SCAN_PWM_EN
        pwm_run(4'd4);
        pwm_run(4'd0);
        pwm_run(4'hF);
`endif

        check("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
